vp_window_cut: RTL and testbench

- Single-clock, parametrised crop/mask stage for the RGB video stream, placed between video input capture and filter/scaler stages.
- Generalises the fixed-window cut with:
  - runtime window registers, shadowed per frame;
  - selectable bypass, crop and mask modes;
  - configurable fill colour;
  - invalid-window detection;
  - frame counting.
- Output is a vs/de/data stream with 1-cycle latency.

---
 rtl/vp_window_cut.sv | 153 +++++++++++++++
 tb/tb_vp_window_cut.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/vp_window_cut.sv
// rtl/vp_window_cut.sv - per-frame shadowed crop/mask window stage for an RGB vs/de/data stream
module vp_window_cut #(
  parameter int DATA_WIDTH = 8,
  parameter int CHANNELS   = 3,
  parameter int X_WIDTH    = 12,
  parameter int Y_WIDTH    = 12,
  parameter int FCNT_WIDTH = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [1:0]                     cfg_mode,
  input  logic [X_WIDTH-1:0]             cfg_start_x,
  input  logic [Y_WIDTH-1:0]             cfg_start_y,
  input  logic [X_WIDTH-1:0]             cfg_end_x,
  input  logic [Y_WIDTH-1:0]             cfg_end_y,
  input  logic [DATA_WIDTH*CHANNELS-1:0] cfg_fill,
  input  logic                           vs_i,
  input  logic                           de_i,
  input  logic [DATA_WIDTH*CHANNELS-1:0] data_i,
  output logic                           vs_o,
  output logic                           de_o,
  output logic [DATA_WIDTH*CHANNELS-1:0] data_o,
  output logic                           state_o,
  output logic                           cfg_err_o,
  output logic [FCNT_WIDTH-1:0]          frame_cnt_o
);
  localparam int PW = DATA_WIDTH * CHANNELS;
  localparam logic [1:0] MODE_CROP = 2'b01;
  localparam logic [1:0] MODE_MASK = 2'b10;

  typedef enum logic {IDLE, FRAME} state_t;

  state_t              st_q, st_d;
  logic                vs_q, vs_d, de_q, de_d, err_q, err_d;
  logic                de_o_q, de_o_d, state_o_q, state_o_d;
  logic [X_WIDTH-1:0]  x_q, x_d, sx_q, sx_d, ex_q, ex_d;
  logic [Y_WIDTH-1:0]  y_q, y_d, sy_q, sy_d, ey_q, ey_d;
  logic [PW-1:0]       fill_q, fill_d, data_o_q, data_o_d;
  logic [1:0]          mode_q, mode_d;
  logic [FCNT_WIDTH-1:0] cnt_q, cnt_d;

  logic                frame_start, line_end, active, col_in, row_in, win_ok, cerr;
  logic [X_WIDTH-1:0]  cx, csx, cex;
  logic [Y_WIDTH-1:0]  cy, csy, cey;
  logic [1:0]          cmode;
  logic [PW-1:0]       cfill;

  always_comb begin
    frame_start = vs_i & ~vs_q;
    line_end    = de_q & ~de_i;
    // A pixel arriving with the vs rise already belongs to the new frame and window
    csx   = frame_start ? cfg_start_x : sx_q;
    csy   = frame_start ? cfg_start_y : sy_q;
    cex   = frame_start ? cfg_end_x   : ex_q;
    cey   = frame_start ? cfg_end_y   : ey_q;
    cmode = frame_start ? cfg_mode    : mode_q;
    cfill = frame_start ? cfg_fill    : fill_q;
    cerr  = frame_start ? ((cfg_start_x >= cfg_end_x) | (cfg_start_y >= cfg_end_y)) : err_q;
    cx    = frame_start ? '0 : x_q;
    cy    = frame_start ? '0 : y_q;

    col_in = (cx >= csx) & (cx < cex);
    row_in = (cy >= csy) & (cy < cey);
    win_ok = col_in & row_in & ~cerr;
    active = (st_q == FRAME) | frame_start;

    vs_d   = vs_i;
    de_d   = de_i;
    sx_d   = csx;
    sy_d   = csy;
    ex_d   = cex;
    ey_d   = cey;
    mode_d = cmode;
    fill_d = cfill;
    err_d  = cerr;

    if (de_i)          x_d = (cx == '1) ? cx : cx + 1'b1;
    else if (line_end) x_d = '0;
    else               x_d = cx;

    if (line_end && !frame_start) y_d = (y_q == '1) ? y_q : y_q + 1'b1;
    else                          y_d = cy;

    st_d  = active ? FRAME : IDLE;
    cnt_d = cnt_q;
    if (frame_start && st_q == FRAME) cnt_d = cnt_q + 1'b1;

    de_o_d   = 1'b0;
    data_o_d = '0;
    if (active) begin
      case (cmode)
        MODE_CROP: begin
          de_o_d   = de_i & win_ok;
          data_o_d = (de_i & win_ok) ? data_i : '0;
        end
        MODE_MASK: begin
          de_o_d   = de_i;
          data_o_d = win_ok ? data_i : cfill;
        end
        default: begin
          de_o_d   = de_i;
          data_o_d = data_i;
        end
      endcase
    end
    state_o_d = active & row_in & ~cerr;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q      <= IDLE;
      vs_q      <= 1'b0;
      de_q      <= 1'b0;
      err_q     <= 1'b0;
      x_q       <= '0;
      y_q       <= '0;
      sx_q      <= '0;
      sy_q      <= '0;
      ex_q      <= '0;
      ey_q      <= '0;
      mode_q    <= '0;
      fill_q    <= '0;
      cnt_q     <= '0;
      de_o_q    <= 1'b0;
      data_o_q  <= '0;
      state_o_q <= 1'b0;
    end else begin
      st_q      <= st_d;
      vs_q      <= vs_d;
      de_q      <= de_d;
      err_q     <= err_d;
      x_q       <= x_d;
      y_q       <= y_d;
      sx_q      <= sx_d;
      sy_q      <= sy_d;
      ex_q      <= ex_d;
      ey_q      <= ey_d;
      mode_q    <= mode_d;
      fill_q    <= fill_d;
      cnt_q     <= cnt_d;
      de_o_q    <= de_o_d;
      data_o_q  <= data_o_d;
      state_o_q <= state_o_d;
    end
  end

  assign vs_o        = vs_q;
  assign de_o        = de_o_q;
  assign data_o      = data_o_q;
  assign state_o     = state_o_q;
  assign cfg_err_o   = err_q;
  assign frame_cnt_o = cnt_q;
endmodule

// File: tb/tb_vp_window_cut.sv
// tb/tb_vp_window_cut.sv - directed bench for vp_window_cut on 16x4 frames
module tb_vp_window_cut;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  cfg_mode;
  logic [11:0] cfg_start_x, cfg_start_y, cfg_end_x, cfg_end_y;
  logic [23:0] cfg_fill;
  logic        vs_i, de_i;
  logic [23:0] data_i;
  logic        vs_o, de_o, state_o, cfg_err_o;
  logic [23:0] data_o;
  logic [15:0] frame_cnt_o;

  int          n_err = 0;
  int          n_checks = 0;
  int          n_de, n_fill, n_pass, byp_bad;
  logic [23:0] first_d, last_d;
  logic [3:0]  state_line;
  logic        err_after_vs;
  int          chg_line = -1;
  int          rst_line = -1;
  int          rst_px = -1;

  vp_window_cut dut (
    .clk(clk), .rst_n(rst_n), .cfg_mode(cfg_mode),
    .cfg_start_x(cfg_start_x), .cfg_start_y(cfg_start_y),
    .cfg_end_x(cfg_end_x), .cfg_end_y(cfg_end_y), .cfg_fill(cfg_fill),
    .vs_i(vs_i), .de_i(de_i), .data_i(data_i),
    .vs_o(vs_o), .de_o(de_o), .data_o(data_o), .state_o(state_o),
    .cfg_err_o(cfg_err_o), .frame_cnt_o(frame_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_win(input logic [11:0] sx, sy, ex, ey);
    cfg_start_x = sx; cfg_start_y = sy; cfg_end_x = ex; cfg_end_y = ey;
  endtask

  task automatic step(input logic vs, input logic de, input logic [23:0] d, input int line);
    vs_i = vs; de_i = de; data_i = d;
    @(posedge clk); #1;
    if (de_o) begin
      n_de++;
      if (n_de == 1) first_d = data_o;
      last_d = data_o;
      if (data_o === cfg_fill) n_fill++;
      if (data_o === d) n_pass++;
    end
    if (vs_o !== vs || de_o !== de || data_o !== d) byp_bad++;
    if (de) state_line[line] = state_line[line] | state_o;
  endtask

  task automatic run_frame();
    n_de = 0; n_fill = 0; n_pass = 0; byp_bad = 0; state_line = '0;
    first_d = 'x; last_d = 'x;
    step(1'b1, 1'b0, 24'h0, 0);
    err_after_vs = cfg_err_o;
    step(1'b0, 1'b0, 24'h0, 0);
    step(1'b0, 1'b0, 24'h0, 0);
    for (int l = 0; l < 4; l++) begin
      if (l == chg_line) set_win(12'd0, 12'd0, 12'd2, 12'd2);
      for (int p = 0; p < 16; p++) begin
        logic [11:0] ly, px;
        ly = 12'(l);
        px = 12'(p);
        if (l == rst_line && p == rst_px) begin
          rst_n = 1'b0;
          #1;
          chk("rst_mid_de", de_o, 0);
          chk("rst_mid_data", data_o, 0);
          chk("rst_mid_state", state_o, 0);
          chk("rst_mid_cnt", frame_cnt_o, 0);
          n_de = 0;
        end
        step(1'b0, 1'b1, {ly, px}, l);
        if (!rst_n) rst_n = 1'b1;
      end
      for (int b = 0; b < 3; b++) step(1'b0, 1'b0, 24'h0, l);
    end
  endtask

  initial begin
    rst_n = 1'b0; vs_i = 1'b0; de_i = 1'b0; data_i = '0;
    cfg_mode = 2'b00; cfg_fill = 24'h0;
    set_win(12'd4, 12'd1, 12'd8, 12'd3);
    repeat (3) @(posedge clk);
    #1;
    chk("reset_vs", vs_o, 0);
    chk("reset_de", de_o, 0);
    chk("reset_data", data_o, 0);
    chk("reset_state", state_o, 0);
    chk("reset_err", cfg_err_o, 0);
    chk("reset_cnt", frame_cnt_o, 0);
    rst_n = 1'b1;

    // no vs seen yet: stream must stay idle
    n_de = 0;
    step(1'b0, 1'b1, 24'h123456, 0);
    step(1'b0, 1'b1, 24'h123457, 0);
    chk("idle_de_count", n_de, 0);
    chk("idle_data", data_o, 0);
    step(1'b0, 1'b0, 24'h0, 0);

    // bypass frames
    run_frame();
    chk("byp1_pixels", n_de, 64);
    chk("byp1_delay_mismatches", byp_bad, 0);
    chk("byp1_cnt", frame_cnt_o, 0);
    run_frame();
    chk("byp2_pixels", n_de, 64);
    chk("byp2_cnt", frame_cnt_o, 1);

    // crop (4,1)-(8,3)
    cfg_mode = 2'b01;
    run_frame();
    chk("crop_pixels", n_de, 8);
    chk("crop_first", first_d, 24'h001004);
    chk("crop_last", last_d, 24'h002007);
    chk("crop_state_lines", state_line, 4'b0110);
    chk("crop_cnt", frame_cnt_o, 2);

    // mask with magenta fill
    cfg_mode = 2'b10; cfg_fill = 24'hFF00FF;
    run_frame();
    chk("mask_pixels", n_de, 64);
    chk("mask_fill", n_fill, 56);
    chk("mask_pass", n_pass, 8);

    // window change mid-frame takes effect next frame
    cfg_mode = 2'b01;
    chg_line = 2;
    run_frame();
    chg_line = -1;
    chk("chg_cur_pixels", n_de, 8);
    chk("chg_cur_first", first_d, 24'h001004);
    run_frame();
    chk("chg_next_pixels", n_de, 4);
    chk("chg_next_first", first_d, 24'h000000);
    chk("chg_next_last", last_d, 24'h001001);

    // invalid window (start_x == end_x)
    set_win(12'd8, 12'd0, 12'd8, 12'd4);
    run_frame();
    chk("err_after_vs", err_after_vs, 1);
    chk("err_pixels", n_de, 0);
    chk("err_state_lines", state_line, 4'b0000);
    set_win(12'd4, 12'd1, 12'd8, 12'd3);
    chk("err_held_until_vs", cfg_err_o, 1);
    run_frame();
    chk("err_cleared_after_vs", err_after_vs, 0);
    chk("err_restored_pixels", n_de, 8);
    chk("cnt_before_reset", frame_cnt_o, 7);

    // reset mid-frame at line 2 pixel 5
    rst_line = 2; rst_px = 5;
    run_frame();
    rst_line = -1; rst_px = -1;
    chk("rst_rest_of_frame_pixels", n_de, 0);
    run_frame();
    chk("post_rst_pixels", n_de, 8);
    chk("post_rst_first", first_d, 24'h001004);
    chk("post_rst_cnt", frame_cnt_o, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
